// File: rtl/harbinger_pkg.sv
// Shared command-word definitions and voice bookkeeping types for the voice allocator.
// The slot age field is sized for the widest supported AGE_W; narrower ages saturate lower.
package harbinger_pkg;

    localparam logic [3:0] NOP       = 4'd0;
    localparam logic [3:0] SET_CMD   = 4'd1;
    localparam logic [3:0] TOGGLE_VC = 4'd2;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 28;
    localparam int MASK_MSB = 27;
    localparam int MASK_LSB = 20;

    localparam int AGE_W_MAX = 16;

    typedef struct packed {
        logic [6:0]           note;
        logic [AGE_W_MAX-1:0] age;
    } voice_slot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2,
        EMIT   = 2'd3
    } va_state_t;

endpackage

// File: rtl/voice_alloc_pick.sv
// Registered best-candidate tracker, fed one voice per scan cycle.
// Note-on: first free voice, else oldest (ties to lowest index). Note-off: lowest-index gated match.
module voice_alloc_pick
    import harbinger_pkg::*;
#(
    parameter int IW = 3
) (
    input  logic          clk147,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    input  logic          mode_on,
    input  logic          gate_bit,
    input  logic [IW-1:0] idx,
    input  voice_slot_t   slot,
    input  logic [6:0]    note_num,
    output logic [IW-1:0] best_idx,
    output logic          found
);

    logic [AGE_W_MAX-1:0] best_age;

    always_ff @(posedge clk147 or negedge rst_n) begin
        if (!rst_n) begin
            best_idx <= '0;
            best_age <= '0;
            found    <= 1'b0;
        end else if (clear) begin
            best_idx <= '0;
            best_age <= '0;
            found    <= 1'b0;
        end else if (en) begin
            if (mode_on) begin
                // Once a free voice is found, no later voice can displace it.
                if (!found) begin
                    if (!gate_bit) begin
                        best_idx <= idx;
                        found    <= 1'b1;
                    end else if (slot.age > best_age) begin
                        best_idx <= idx;
                        best_age <= slot.age;
                    end
                end
            end else if (!found && gate_bit && (slot.note == note_num)) begin
                best_idx <= idx;
                found    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans voices per note event and emits one TOGGLE_VC word per gate change.
// Optional VOICE_ALLOC_STATS_EN adds a saturating steal_count output.
//
// state  | meaning
// IDLE   | note_ready high, waiting for an event
// SCAN   | one voice examined per cycle, index 0..NUM_VOICES-1
// UPDATE | apply winner to gate/age/note, build command word
// EMIT   | hold cmd_valid/cmd_data until consumer accepts
module voice_alloc
    import harbinger_pkg::*;
#(
    parameter int NUM_VOICES = 6,
    parameter int AGE_W      = 8
) (
    input  logic                  clk147,
    input  logic                  rst_n,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic                  note_on,
    input  logic [6:0]            note_num,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [31:0]           cmd_data,
    output logic [NUM_VOICES-1:0] gate
`ifdef VOICE_ALLOC_STATS_EN
    ,
    output logic [15:0]           steal_count
`endif
);

    localparam int IW = 3;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);
    localparam logic [AGE_W_MAX-1:0] AGE_SAT = AGE_W_MAX'((64'd1 << AGE_W) - 64'd1);

    va_state_t             state, next_state;
    logic [IW-1:0]         scan_idx;
    logic                  ev_on;
    logic [6:0]            ev_note;
    voice_slot_t           slots [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_upd;
    logic [IW-1:0]         win_idx;
    logic                  win_found;
    logic                  take;
    logic [31:0]           cmd_word;

    assign take = note_valid && note_ready;
    assign gate = gate_q;

    voice_alloc_pick #(.IW(IW)) u_pick (
        .clk147   (clk147),
        .rst_n    (rst_n),
        .clear    (take),
        .en       (state == SCAN),
        .mode_on  (ev_on),
        .gate_bit (gate_q[scan_idx]),
        .idx      (scan_idx),
        .slot     (slots[scan_idx]),
        .note_num (ev_note),
        .best_idx (win_idx),
        .found    (win_found)
    );

    always_ff @(posedge clk147 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = take ? SCAN : IDLE;
            SCAN:    next_state = (scan_idx == LAST_IDX) ? UPDATE : SCAN;
            UPDATE:  next_state = (ev_on || win_found) ? EMIT : IDLE;
            EMIT:    next_state = cmd_ready ? IDLE : EMIT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gate_upd = gate_q;
        if (ev_on)          gate_upd[win_idx] = 1'b1;
        else if (win_found) gate_upd[win_idx] = 1'b0;
    end

    always_comb begin
        cmd_word                   = '0;
        cmd_word[OPC_MSB:OPC_LSB]   = TOGGLE_VC;
        cmd_word[MASK_MSB:MASK_LSB] = 8'(gate_upd);
        cmd_word[10:8]             = win_idx;
        cmd_word[7]                = ev_on;
        cmd_word[6:0]              = ev_note;
    end

    always_ff @(posedge clk147 or negedge rst_n) begin
        if (!rst_n) begin
            note_ready <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_data   <= '0;
            gate_q     <= '0;
            scan_idx   <= '0;
            ev_on      <= 1'b0;
            ev_note    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) slots[v] <= '0;
        end else begin
            // Registered so it stays low while reset is asserted and drops right after a transfer.
            note_ready <= (next_state == IDLE);
            case (state)
                IDLE: begin
                    if (take) begin
                        ev_on    <= note_on;
                        ev_note  <= note_num;
                        scan_idx <= '0;
                    end
                end
                SCAN: scan_idx <= scan_idx + 1'b1;
                UPDATE: begin
                    if (ev_on) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (IW'(v) == win_idx) begin
                                slots[v].note <= ev_note;
                                slots[v].age  <= '0;
                            end else if (gate_q[v] && (slots[v].age != AGE_SAT)) begin
                                slots[v].age <= slots[v].age + 1'b1;
                            end
                        end
                    end else if (win_found) begin
                        slots[win_idx].age <= '0;
                    end
                    if (ev_on || win_found) begin
                        gate_q    <= gate_upd;
                        cmd_valid <= 1'b1;
                        cmd_data  <= cmd_word;
                    end
                end
                EMIT: if (cmd_ready) cmd_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef VOICE_ALLOC_STATS_EN
    always_ff @(posedge clk147 or negedge rst_n) begin
        if (!rst_n)
            steal_count <= '0;
        else if ((state == UPDATE) && ev_on && !win_found && (steal_count != 16'hFFFF))
            steal_count <= steal_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed scenarios plus randomized note traffic
// checked against an array-based voice model.
module tb_voice_alloc;
    import harbinger_pkg::*;

    localparam int NV = 6;

    logic          clk147 = 1'b0;
    logic          rst_n = 1'b0;
    logic          note_valid = 1'b0;
    logic          note_on = 1'b0;
    logic [6:0]    note_num = '0;
    logic          cmd_ready = 1'b1;
    logic          note_ready;
    logic          cmd_valid;
    logic [31:0]   cmd_data;
    logic [NV-1:0] gate;
`ifdef VOICE_ALLOC_STATS_EN
    logic [15:0]   steal_count;
`endif

    voice_alloc #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk147      (clk147),
        .rst_n       (rst_n),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_on     (note_on),
        .note_num    (note_num),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .gate        (gate)
`ifdef VOICE_ALLOC_STATS_EN
        ,
        .steal_count (steal_count)
`endif
    );

    always #5 clk147 = ~clk147;

    int n_pass = 0;
    int n_total = 0;

    bit m_held [NV];
    int m_note [NV];
    int m_age  [NV];
    int m_steals = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_mask();
        logic [31:0] r;
        r = '0;
        for (int v = 0; v < NV; v++) if (m_held[v]) r[v] = 1'b1;
        return r;
    endfunction

    function automatic void m_clear();
        for (int v = 0; v < NV; v++) begin
            m_held[v] = 1'b0;
            m_note[v] = 0;
            m_age[v]  = 0;
        end
        m_steals = 0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        m_clear();
        repeat (2) @(negedge clk147);
        check("rst_note_ready", 32'(note_ready), 0);
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_gate", 32'(gate), 0);
        rst_n = 1'b1;
        @(negedge clk147);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            if (note_ready) break;
            @(negedge clk147);
        end
        check("ready_wait", 32'(note_ready), 1);
    endtask

    task automatic send(input bit on, input logic [6:0] num, input int stall);
        int          w;
        bit          found;
        bit          seen;
        int          lat;
        logic [31:0] exp_word;
        logic [31:0] gate_before;

        w = 0;
        found = 1'b0;
        if (on) begin
            for (int v = 0; v < NV; v++)
                if (!found && !m_held[v]) begin w = v; found = 1'b1; end
            if (!found) begin
                w = 0;
                for (int v = 1; v < NV; v++) if (m_age[v] > m_age[w]) w = v;
                m_steals++;
            end
            for (int v = 0; v < NV; v++)
                if (v != w && m_held[v] && m_age[v] < 255) m_age[v]++;
            m_held[w] = 1'b1;
            m_note[w] = int'(num);
            m_age[w]  = 0;
        end else begin
            for (int v = 0; v < NV; v++)
                if (!found && m_held[v] && m_note[v] == int'(num)) begin w = v; found = 1'b1; end
            if (found) begin
                m_held[w] = 1'b0;
                m_age[w]  = 0;
            end
        end
        exp_word = 32'h2000_0000 | (m_mask() << 20) | (32'(w) << 8) | (32'(on) << 7) | 32'(num);

        wait_ready();
        gate_before = 32'(gate);
        cmd_ready  = (stall > 0) ? 1'b0 : 1'b1;
        note_on    = on;
        note_num   = num;
        note_valid = 1'b1;
        @(posedge clk147);
        @(negedge clk147);
        note_valid = 1'b0;
        check("ready_drop", 32'(note_ready), 0);

        if (on || found) begin
            lat = 1;
            for (int i = 0; i < 30; i++) begin
                if (cmd_valid) break;
                lat++;
                @(negedge clk147);
            end
            check("latency", 32'(lat), 32'(NV + 2));
            check("cmd_data", cmd_data, exp_word);
            check("gate", 32'(gate), m_mask());
            for (int i = 0; i < stall; i++) begin
                @(negedge clk147);
                check("stall_valid", 32'(cmd_valid), 1);
                check("stall_data", cmd_data, exp_word);
                check("stall_ready", 32'(note_ready), 0);
            end
            cmd_ready = 1'b1;
            @(negedge clk147);
            check("cmd_drop", 32'(cmd_valid), 0);
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (cmd_valid) seen = 1'b1;
                @(negedge clk147);
            end
            check("no_cmd", 32'(seen), 0);
            check("miss_gate", 32'(gate), gate_before);
            check("miss_ready", 32'(note_ready), 1);
        end
    endtask

    initial begin
        bit seen;
        m_clear();
        @(negedge clk147);
        do_reset();

        send(1'b1, 7'd60, 0);
        check("first_word", cmd_data, 32'h2010_00BC);
        check("first_gate", 32'(gate), 32'h01);

        for (int n = 61; n <= 65; n++) send(1'b1, 7'(n), 0);
        check("full_gate", 32'(gate), 32'h3F);
        send(1'b1, 7'd70, 0);
        check("steal_word", cmd_data, 32'h23F0_00C6);
`ifdef VOICE_ALLOC_STATS_EN
        check("steal_count", 32'(steal_count), 1);
`endif

        do_reset();
        send(1'b1, 7'd60, 0);
        send(1'b1, 7'd61, 0);
        send(1'b1, 7'd62, 0);
        send(1'b0, 7'd61, 0);
        check("off_word", cmd_data, 32'h2050_013D);
        check("off_gate", 32'(gate), 32'h05);

        send(1'b0, 7'd99, 0);
        send(1'b1, 7'd63, 10);

        wait_ready();
        note_on    = 1'b1;
        note_num   = 7'd64;
        note_valid = 1'b1;
        @(posedge clk147);
        @(negedge clk147);
        note_valid = 1'b0;
        @(negedge clk147);
        #2 rst_n = 1'b0;
        #1;
        check("async_gate", 32'(gate), 0);
        check("async_valid", 32'(cmd_valid), 0);
        check("async_data", cmd_data, 0);
        check("async_ready", 32'(note_ready), 0);
`ifdef VOICE_ALLOC_STATS_EN
        check("async_steal", 32'(steal_count), 0);
`endif
        m_clear();
        @(negedge clk147);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (cmd_valid) seen = 1'b1;
            @(negedge clk147);
        end
        check("rst_no_cmd", 32'(seen), 0);
        send(1'b1, 7'd60, 0);
        check("post_rst_idx", 32'(cmd_data[10:8]), 0);

        for (int k = 0; k < 40; k++) begin
            send(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 7'(40 + $urandom_range(0, 9)),
                 int'($urandom_range(0, 2)));
        end
`ifdef VOICE_ALLOC_STATS_EN
        check("final_steal", 32'(steal_count), 32'(m_steals));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
